// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared types and constants for the I2C register target
//
// Purpose: state encoding, R/W bit meaning and register-address geometry
// shared by the I2C target blocks.
// Ports: none (package).
package iic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    ADDR_HI,
    ADDR_HI_ACK,
    ADDR_LO,
    ADDR_LO_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } iic_state_e;

  localparam logic RW_WRITE   = 1'b0;
  localparam logic RW_READ    = 1'b1;
  localparam int   ADDR_BYTES = 2;

endpackage

// File: rtl/iic_in_filter.sv
// rtl/iic_in_filter.sv - synchronizer, glitch filter and edge detect for one bus line
//
// Purpose: brings an asynchronous open-drain bus line into the sys_clk domain,
// rejects pulses shorter than FILTER_LEN samples and flags accepted edges.
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset (filtered level resets to 1)
//   din_i    raw asynchronous line
//   level_o  filtered level
//   rise_o   one-cycle pulse when level_o goes 0->1
//   fall_o   one-cycle pulse when level_o goes 1->0
module iic_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // cnt_q counts consecutive synchronized samples that disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[SYNC_STAGES-1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
        rise_q  <= ~level_q;
        fall_q  <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/iic_slave_regs.sv
// rtl/iic_slave_regs.sv - I2C target with 16-bit register pointer and 8-bit data
//
// Purpose: responds at DEV_ADDR, takes a two-byte register pointer, then
// writes data bytes (reg_wr_en) or reads them (reg_rd_req / reg_rd_data),
// auto-incrementing the pointer. Open-drain: only ever pulls SDA low.
// Ports:
//   sys_clk, sys_rst_n   clock and synchronous active-low reset
//   scl, sda_in          asynchronous bus inputs
//   sda_out, sda_out_en  open-drain data value (0) and pull-low enable
//   reg_wr_en            one-cycle write strobe with reg_addr / reg_wr_data
//   reg_rd_req           one-cycle read request with reg_addr
//   reg_rd_data          read data, sampled one cycle after reg_rd_req
//   busy                 addressed transaction in progress
module iic_slave_regs
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2B,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        sda_out_en,
  output logic        reg_wr_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_req,
  input  logic [7:0]  reg_rd_data,
  output logic        busy
);

  localparam int PTR_W = ADDR_BYTES * 8;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(sys_clk), .rst_n_i(sys_rst_n), .din_i(scl),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  iic_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(sys_clk), .rst_n_i(sys_rst_n), .din_i(sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  iic_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             ack_drv_q, ack_drv_d;
  logic             busy_q, busy_d;
  logic             oe_q, oe_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic             rd_pend_q, rd_pend_d;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  // The DEV_ADDR parameter shadows the state of the same name, so states
  // are referenced through the package scope where the two could collide.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_drv_d = ack_drv_q;
    busy_d    = busy_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_pend_d = rd_req_q;

    // Pointer advances the cycle after the write strobe so the strobe
    // carries the un-incremented address.
    if (wr_en_q) ptr_d = ptr_q + 1'b1;
    if (rd_pend_q) tx_d = reg_rd_data;

    if (start_det) begin
      state_d   = iic_pkg::DEV_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        iic_pkg::DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              case (state_q)
                iic_pkg::DEV_ADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = DEV_ACK;
                    busy_d  = 1'b1;
                    rw_d    = rx_byte[0];
                  end else begin
                    state_d = IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                ADDR_HI: begin
                  ptr_d[15:8] = rx_byte;
                  state_d     = ADDR_HI_ACK;
                end
                ADDR_LO: begin
                  ptr_d[7:0] = rx_byte;
                  state_d    = ADDR_LO_ACK;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_data_d = rx_byte;
                  state_d   = WR_ACK;
                end
              endcase
            end
          end
        end
        // First fall drives the ACK, second fall releases it and moves on.
        DEV_ACK, ADDR_HI_ACK, ADDR_LO_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              oe_d      = 1'b1;
              ack_drv_d = 1'b1;
              if (state_q == DEV_ACK && rw_q == RW_READ) rd_req_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              ack_drv_d = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                DEV_ACK: begin
                  if (rw_q == RW_WRITE) begin
                    state_d = ADDR_HI;
                  end else begin
                    // Same fall that ends the ACK presents the first read bit.
                    state_d = RD_DATA;
                    oe_d    = ~tx_q[7];
                    tx_d    = {tx_q[6:0], 1'b0};
                  end
                end
                ADDR_HI_ACK: state_d = ADDR_LO;
                default:     state_d = WR_DATA;
              endcase
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RD_ACK;
            end else begin
              oe_d = ~tx_q[7];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              ptr_d     = ptr_q + 1'b1;
              rd_req_d  = 1'b1;
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= RW_WRITE;
      ack_drv_q <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      ack_drv_q <= ack_drv_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign sda_out     = 1'b0;
  assign sda_out_en  = oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_addr    = ptr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_req  = rd_req_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// tb/tb_iic_slave_regs.sv - directed bench for the I2C register target
`timescale 1ns/1ps
module tb_iic_slave_regs;
  import iic_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_out, sda_out_en, reg_wr_en, reg_rd_req, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wr_data;
  logic [7:0]  rd_model = 8'h00;
  wire         sda_bus = sda_m & (sda_out_en ? sda_out : 1'b1);

  int checks = 0;
  int errors = 0;

  iic_slave_regs #(.DEV_ADDR(7'h2B), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl_m), .sda_in(sda_bus),
    .sda_out(sda_out), .sda_out_en(sda_out_en), .reg_wr_en(reg_wr_en),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_req(reg_rd_req),
    .reg_rd_data(rd_model), .busy(busy)
  );

  always #50 sys_clk = ~sys_clk;

  // Register-file model: read data = low address byte inverted, registered.
  always @(posedge sys_clk) if (reg_rd_req) rd_model <= reg_addr[7:0] ^ 8'hFF;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         wr_log[$];
  logic [15:0] rd_log[$];
  int          oe_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge sys_clk) begin
    if (reg_wr_en) wr_log.push_back('{reg_addr, reg_wr_data});
    if (reg_rd_req) rd_log.push_back(reg_addr);
    if (sda_out_en) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Quarter of a 400 kHz bit at 10 MHz sys_clk: each SCL phase is 12 cycles.
  task automatic qw();
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic bit_io(input logic b, input logic glitch, output logic s);
    sda_m = b;
    qw();
    scl_m = 1'b1;
    qw();
    s = sda_bus;
    if (glitch) begin
      repeat (2) @(negedge sys_clk);
      scl_m = 1'b0;
      @(negedge sys_clk);
      scl_m = 1'b1;
      repeat (3) @(negedge sys_clk);
    end else begin
      qw();
    end
    scl_m = 1'b0;
    qw();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw();
    qw();
  endtask

  task automatic write_byte(input logic [7:0] b, input int gi, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], (i == gi), s);
    bit_io(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_io(nack, 1'b0, s);
  endtask

  typedef struct {
    logic [6:0]  dev;
    logic [15:0] addr;
    int          n;
    logic [23:0] data;
    logic        exp_ack;
    int          exp_wr;
    logic [47:0] exp_addr;
    int          gbit;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic       ack;
    logic [7:0] d;
    int         wr_base, oe_base, busy_base, rd_base;

    tbl[0] = '{7'h2B, 16'h1234, 1, 24'h00005A, 1'b1, 1, 48'h0000_0000_1234, -1};
    tbl[1] = '{7'h2B, 16'hFFFF, 3, 24'h030201, 1'b1, 3, 48'h0001_0000_FFFF, -1};
    tbl[2] = '{7'h2C, 16'h1234, 1, 24'h00005A, 1'b0, 0, 48'h0000_0000_0000, -1};
    tbl[3] = '{7'h2B, 16'h0042, 1, 24'h0000A5, 1'b1, 1, 48'h0000_0000_0042, 4};

    repeat (5) @(negedge sys_clk);
    chk("rst_oe", sda_out_en, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_req", reg_rd_req, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wr_data", reg_wr_data, 0);
    chk("rst_busy", busy, 0);
    sys_rst_n = 1'b1;
    qw();

    for (int v = 0; v < 4; v++) begin
      wr_base   = wr_log.size();
      oe_base   = oe_cnt;
      busy_base = busy_cnt;
      i2c_start();
      write_byte({tbl[v].dev, 1'b0}, -1, ack);
      chk($sformatf("v%0d_dev_ack", v), ack, tbl[v].exp_ack);
      if (tbl[v].exp_ack) chk($sformatf("v%0d_busy_mid", v), busy, 1);
      write_byte(tbl[v].addr[15:8], -1, ack);
      chk($sformatf("v%0d_ahi_ack", v), ack, tbl[v].exp_ack);
      write_byte(tbl[v].addr[7:0], -1, ack);
      chk($sformatf("v%0d_alo_ack", v), ack, tbl[v].exp_ack);
      for (int i = 0; i < tbl[v].n; i++) begin
        write_byte(tbl[v].data[i*8 +: 8], tbl[v].gbit, ack);
        chk($sformatf("v%0d_d%0d_ack", v, i), ack, tbl[v].exp_ack);
      end
      i2c_stop();
      chk($sformatf("v%0d_busy_end", v), busy, 0);
      chk($sformatf("v%0d_wr_cnt", v), wr_log.size() - wr_base, tbl[v].exp_wr);
      for (int i = 0; i < tbl[v].exp_wr; i++) begin
        if (wr_base + i < wr_log.size()) begin
          chk($sformatf("v%0d_wr%0d_addr", v, i), wr_log[wr_base+i].a, tbl[v].exp_addr[i*16 +: 16]);
          chk($sformatf("v%0d_wr%0d_data", v, i), wr_log[wr_base+i].d, tbl[v].data[i*8 +: 8]);
        end
      end
      if (!tbl[v].exp_ack) begin
        chk($sformatf("v%0d_oe_never", v), oe_cnt - oe_base, 0);
        chk($sformatf("v%0d_busy_never", v), busy_cnt - busy_base, 0);
      end
    end

    // Set pointer to 0x00A0, repeated START, read two bytes.
    rd_base = rd_log.size();
    i2c_start();
    write_byte({7'h2B, RW_WRITE}, -1, ack);
    chk("rd_devw_ack", ack, 1);
    write_byte(8'h00, -1, ack);
    chk("rd_ahi_ack", ack, 1);
    write_byte(8'hA0, -1, ack);
    chk("rd_alo_ack", ack, 1);
    i2c_start();
    write_byte({7'h2B, RW_READ}, -1, ack);
    chk("rd_devr_ack", ack, 1);
    read_byte(1'b0, d);
    chk("rd_byte0", d, 8'h5F);
    read_byte(1'b1, d);
    chk("rd_byte1", d, 8'h5E);
    chk("rd_release", sda_out_en, 0);
    i2c_stop();
    chk("rd_req_cnt", rd_log.size() - rd_base, 2);
    if (rd_log.size() - rd_base >= 2) begin
      chk("rd_req0_addr", rd_log[rd_base], 16'h00A0);
      chk("rd_req1_addr", rd_log[rd_base+1], 16'h00A1);
    end
    chk("rd_busy_end", busy, 0);

    // STOP after four data bits of a write byte.
    wr_base = wr_log.size();
    i2c_start();
    write_byte({7'h2B, RW_WRITE}, -1, ack);
    write_byte(8'h00, -1, ack);
    write_byte(8'h10, -1, ack);
    chk("stp_alo_ack", ack, 1);
    begin
      logic s;
      bit_io(1'b1, 1'b0, s);
      bit_io(1'b0, 1'b0, s);
      bit_io(1'b1, 1'b0, s);
      bit_io(1'b1, 1'b0, s);
    end
    i2c_stop();
    chk("stp_wr_cnt", wr_log.size() - wr_base, 0);
    chk("stp_state", dut.state_q, IDLE);
    chk("stp_oe", sda_out_en, 0);
    chk("stp_busy", busy, 0);

    // Reset while the target is driving the device-address ACK.
    i2c_start();
    begin
      logic s;
      logic [7:0] b;
      b = {7'h2B, RW_WRITE};
      for (int i = 7; i >= 0; i--) bit_io(b[i], 1'b0, s);
    end
    sda_m = 1'b1;
    for (int k = 0; k < 40 && !sda_out_en; k++) @(negedge sys_clk);
    chk("rst_ack_on", sda_out_en, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_ack_oe", sda_out_en, 0);
    chk("rst_ack_busy", busy, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    qw();
    scl_m = 1'b1;
    qw();
    qw();
    chk("rst_after_state", dut.state_q, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #8ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
- Synthesizable I2C target (responder) with 16-bit register address and 8-bit data, the responder end of the two-byte-address I2C protocol used by the MS72xx init path.
- Exposes a simple register-port handshake to fabric logic.
- Used for board loopback tests of the I2C master path, and for exposing FPGA control/status registers over the HDMI-side I2C bus.
- Open-drain: drives SDA low only, never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h2B, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (min 2).
- FILTER_LEN, 3, consecutive equal synchronized samples needed to accept a new SCL/SDA level (glitch filter).

Ports:
- sys_clk, input, 1, system clock; all logic on rising edge.
- sys_rst_n, input, 1, reset; synchronous, active-low.
- scl, input, 1, I2C clock from the bus (asynchronous).
- sda_in, input, 1, I2C data from the bus (asynchronous).
- sda_out, output, 1, constant 0 (open-drain data value).
- sda_out_en, output, 1, 1 = pull SDA low; pad logic forms the tristate.
- reg_wr_en, output, 1, one-cycle write strobe.
- reg_addr, output, 16, register address for the current write or read request.
- reg_wr_data, output, 8, write data; valid while reg_wr_en = 1.
- reg_rd_req, output, 1, one-cycle read request.
- reg_rd_data, input, 8, read data; sampled exactly 1 cycle after reg_rd_req.
- busy, output, 1, high from an addressed START (address match) until STOP, or until release after a mismatch.

Behaviour:
- Reset values: sda_out_en=0, reg_wr_en=0, reg_rd_req=0, reg_addr=0, reg_wr_data=0, busy=0, state=IDLE, filtered scl/sda=1.
- Input path: SYNC_STAGES-deep flop chain, then the FILTER_LEN glitch filter. Edge detects (scl_rise, scl_fall, sda_rise, sda_fall) are derived from the filtered levels.
- Supported bus rate: each SCL high/low phase must be at least SYNC_STAGES+FILTER_LEN+4 sys_clk cycles (10 MHz at 400 kHz gives 12 cycles, which is sufficient).
- START: sda_fall while filtered scl=1. STOP: sda_rise while scl=1. Both are honoured in every state and take priority over bit processing.
  - START (including repeated START) goes to DEV_ADDR with bit count 0.
  - STOP goes to IDLE, releases SDA, and clears busy.
- Bit timing: sample SDA on scl_rise; change sda_out_en on scl_fall only.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits, MSB first. After the 8th rise, compare the upper 7 bits to DEV_ADDR.
    - Match: go to DEV_ACK and set busy.
    - Mismatch: go to IGNORE, with SDA never driven.
  - DEV_ACK: assert sda_out_en on the next scl_fall; release on the following scl_fall.
    - R/W=0: go to ADDR_HI.
    - R/W=1: pulse reg_rd_req with the current address pointer at the first scl_fall of DEV_ACK, latch reg_rd_data 1 cycle later into the tx shifter, then go to RD_DATA.
  - ADDR_HI / ADDR_LO: shift 8 bits into the pointer high/low byte; each is followed by an ACK phase as above.
  - WR_DATA: shift 8 bits, then ACK. At the 8th scl_rise, pulse reg_wr_en for 1 cycle with reg_addr=pointer and reg_wr_data=byte. Pointer increments after the pulse. Repeats until STOP or START.
  - RD_DATA: drive the tx shifter MSB first. sda_out_en = ~bit, updated on each scl_fall; the first bit is set up on the scl_fall that ends DEV_ACK/RD_ACK. Release after the 8th bit.
  - RD_ACK: sample the master bit on scl_rise.
    - ACK (0): pointer+1, pulse reg_rd_req, reload, return to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- Pointer: 16-bit, wraps 16'hFFFF to 16'h0000. It persists across transactions, so a write-address-only transaction followed by a repeated START read reads from that address.
- reg_addr always reflects the pointer.
- Simultaneous START and bit edge: START wins, and the partial byte is discarded with no reg_wr_en.
- STOP mid-byte: partial byte discarded, SDA released within 1 cycle.
- Reset mid-transfer: sda_out_en drops on the reset cycle; busy=0.

Decomposition:
- Shared package iic_pkg:
  - state enum constants (IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ADDR_HI_ACK, ADDR_LO, ADDR_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - RW_WRITE=0 and RW_READ=1;
  - ADDR_BYTES=2.
- One sub-module: iic_in_filter (synchronizer + glitch filter + edge detect), instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write 0x5A to 16'h1234 at 400 kHz (sys_clk 10 MHz) -> ACK on 4 bytes; exactly one reg_wr_en with reg_addr=16'h1234, reg_wr_data=8'h5A; busy falls at STOP.
- Burst write 0x01,0x02,0x03 to 16'hFFFF -> three reg_wr_en pulses at addresses 16'hFFFF, 16'h0000, 16'h0001 (wrap).
- Set address 16'h00A0, repeated START read of 2 bytes, model returns addr[7:0]^8'hFF -> bus reads 8'h5F then 8'h5E; master NACK on 2nd byte; exactly 2 reg_rd_req pulses; SDA released before STOP.
- Address 7'h2C (mismatch) write -> master sees NACK; sda_out_en never asserted; no reg_wr_en; busy stays 0.
- STOP after 4 data bits of a WR_DATA byte -> no reg_wr_en; state IDLE; sda_out_en=0.
- 1-cycle glitch on SCL while SCL is high mid-byte -> ignored, data correct; sys_rst_n=0 during DEV_ACK -> sda_out_en=0 on the following clock edge.
